// File: rtl/stack_arbiter.sv
// stack_arbiter
//   Shares one synchronous push/pop stack between two requesters (r0, r1).
//   Transactions are serialised onto the stack port one at a time. The
//   arbiter tracks occupancy itself, so overflow and underflow are rejected
//   with an error ack and never reach the stack.
//
// Handshake: rN_req acts as "valid". It is raised together with a stable
//   rN_op (1=push, 0=pop) and rN_wdata, and held until rN_ack. rN_ack is a
//   single-cycle completion pulse. rN_err and, for a successful pop, rN_rdata
//   are valid in the same cycle as rN_ack. A req still high in IDLE after its
//   ack starts a new transaction.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   rN_req/op/wdata           requester N transaction inputs
//   rN_ack/err/rdata          requester N completion outputs
//   stk_push/pop/data_in      strobes and write data to the stack
//   stk_data_out, stk_empty   stack read data (valid the cycle after a pop)
//                             and empty flag (consistency check only)
//   count                     occupancy as tracked by the arbiter
//   dbg_state                 current FSM state (IDLE=0 ISSUE=1 CAPTURE=2 RESP=3)
//
// Build option:
//   STACK_ARB_FIXED_PRIO_EN   when defined, r0 always wins a tie (r1 may
//                             starve); otherwise ties are round-robin.

module stack_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  r0_req,
    input  logic                  r0_op,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ack,
    output logic                  r0_err,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_op,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ack,
    output logic                  r1_err,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_data_in,
    input  logic [DATA_WIDTH-1:0] stk_data_out,
    input  logic                  stk_empty,
    output logic [CNT_W-1:0]      count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    state_t                state;
    logic                  op_q;
    logic                  id_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  grant_any;
    logic                  grant_id;
    logic                  sel_op;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef STACK_ARB_FIXED_PRIO_EN
    // r1 only wins when r0 is idle.
    always_comb begin
        grant_any = r0_req | r1_req;
        grant_id  = ~r0_req;
    end
`else
    // rr_last holds the id of the last requester served; a tie goes to the
    // other one. Reset value 1 makes r0 win the first tie.
    logic rr_last;

    always_comb begin
        grant_any = r0_req | r1_req;
        if (r0_req && r1_req) begin
            grant_id = ~rr_last;
        end else begin
            grant_id = ~r0_req;
        end
    end
`endif

    always_comb begin
        sel_op    = grant_id ? r1_op    : r0_op;
        sel_wdata = grant_id ? r1_wdata : r0_wdata;
    end

    assign dbg_state = state;

    // Stack strobes are registered on the IDLE->ISSUE transition so they are
    // high exactly during the ISSUE cycle. The same saturation decision is
    // repeated in ISSUE to update count and err (count is unchanged between).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op_q        <= 1'b0;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            count       <= '0;
            r0_ack      <= 1'b0;
            r0_err      <= 1'b0;
            r0_rdata    <= '0;
            r1_ack      <= 1'b0;
            r1_err      <= 1'b0;
            r1_rdata    <= '0;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_data_in <= '0;
`ifndef STACK_ARB_FIXED_PRIO_EN
            rr_last     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                    r0_err <= 1'b0;
                    r1_err <= 1'b0;
                    err_q  <= 1'b0;
                    if (grant_any) begin
                        id_q    <= grant_id;
                        op_q    <= sel_op;
                        wdata_q <= sel_wdata;
                        if (sel_op && (count != FULL)) begin
                            stk_push    <= 1'b1;
                            stk_data_in <= sel_wdata;
                        end else if (!sel_op && (count != '0)) begin
                            stk_pop <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    stk_push <= 1'b0;
                    stk_pop  <= 1'b0;
                    if (op_q) begin
                        if (count != FULL) begin
                            count <= count + 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state <= RESP;
                    end else if (count != '0) begin
                        count <= count - 1'b1;
                        state <= CAPTURE;
                    end else begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end
                end
                CAPTURE: begin
                    if (id_q) begin
                        r1_rdata <= stk_data_out;
                    end else begin
                        r0_rdata <= stk_data_out;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (id_q) begin
                        r1_ack <= 1'b1;
                        r1_err <= err_q;
                    end else begin
                        r0_ack <= 1'b1;
                        r0_err <= err_q;
                    end
`ifndef STACK_ARB_FIXED_PRIO_EN
                    rr_last <= id_q;
`endif
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // The attached stack's empty flag must agree with the tracked occupancy
    // whenever no transaction is in flight.
    a_empty_consistent: assert property (
        @(posedge clk) disable iff (!reset_n)
        (state == IDLE) |-> (stk_empty == (count == '0))
    );
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk;
    logic          reset_n;
    logic          r0_req, r0_op, r0_ack, r0_err;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_op, r1_ack, r1_err;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          stk_push, stk_pop, stk_empty;
    logic [DW-1:0] stk_data_in, stk_data_out;
    logic [CW-1:0] count;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    stack_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_op(r0_op), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_op(r1_op), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_empty(stk_empty),
        .count(count), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural stack ----------------
    logic [DW-1:0] mem [DEPTH];
    int            sp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp           <= 0;
            stk_data_out <= '0;
        end else if (stk_push && sp < DEPTH) begin
            mem[sp] <= stk_data_in;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end
    assign stk_empty = (sp == 0);

    // ---------------- strobe monitor ----------------
    int            push_cnt = 0;
    int            pop_cnt  = 0;
    bit            both_seen = 0;
    logic [DW-1:0] push_log[$];
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (stk_push && stk_pop) both_seen = 1;
        if (stk_push) begin
            push_cnt++;
            push_log.push_back(stk_data_in);
        end
        if (stk_pop) pop_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset_n = 1'b0;
        r0_req = 0; r1_req = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_txn(input bit id, input bit op, input logic [DW-1:0] wd,
                          output bit err, output logic [DW-1:0] rd, output int lat);
        bit done;
        done = 0; lat = 0; err = 0; rd = '0;
        @(negedge clk);
        if (id == 0) begin r0_req = 1; r0_op = op; r0_wdata = wd; end
        else         begin r1_req = 1; r1_op = op; r1_wdata = wd; end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            lat++;
            if ((id == 0) ? r0_ack : r1_ack) begin
                done = 1;
                err  = (id == 0) ? r0_err : r1_err;
                rd   = (id == 0) ? r0_rdata : r1_rdata;
                checks++;
                if (((id == 0) ? r1_ack : r0_ack) !== 1'b0) begin
                    errors++;
                    $display("FAIL other_ack id=%0d: other requester ack=1, required 0", id);
                end
            end
        end
        r0_req = 0; r1_req = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL txn_timeout id=%0d op=%0d: no ack in 20 cycles, required ack", id, op);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        r0_req = 0; r0_op = 0; r0_wdata = '0;
        r1_req = 0; r1_op = 0; r1_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({r0_ack, r0_err, r1_ack, r1_err, stk_push, stk_pop} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {r0_ack, r0_err, r1_ack, r1_err, stk_push, stk_pop});
        end
        checks++;
        if ({r0_rdata, r1_rdata, stk_data_in} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 000000", {r0_rdata, r1_rdata, stk_data_in});
        end
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", count);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, required 0", dbg_state);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_push_basic();
        bit err; logic [DW-1:0] rd; int lat; int p0;
        p0 = push_cnt;
        push_log.delete();
        do_txn(0, 1, 8'hA4, err, rd, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL push_latency: got %0d, required 3", lat); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL push_err: got %b, required 0", err); end
        checks++;
        if (push_cnt - p0 !== 1 || push_log.size() != 1) begin
            errors++; $display("FAIL push_strobe: got %0d cycles, required 1", push_cnt - p0);
        end else begin
            checks++;
            if (push_log[0] !== 8'hA4) begin
                errors++; $display("FAIL push_data: got %h, required a4", push_log[0]);
            end
        end
        checks++;
        if (count !== 5'd1) begin errors++; $display("FAIL push_count: got %0d, required 1", count); end
    endtask

    task automatic test_pop_basic();
        bit err; logic [DW-1:0] rd; int lat; int q0;
        q0 = pop_cnt;
        do_txn(1, 0, 8'h00, err, rd, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL pop_latency: got %0d, required 4", lat); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL pop_err: got %b, required 0", err); end
        checks++;
        if (rd !== 8'hA4) begin errors++; $display("FAIL pop_rdata: got %h, required a4", rd); end
        checks++;
        if (pop_cnt - q0 !== 1) begin errors++; $display("FAIL pop_strobe: got %0d, required 1", pop_cnt - q0); end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL pop_count: got %0d, required 0", count); end
    endtask

    task automatic test_underflow();
        bit err; logic [DW-1:0] rd; int lat; int q0;
        q0 = pop_cnt;
        do_txn(0, 0, 8'h00, err, rd, lat);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b, required 1", err); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL underflow_latency: got %0d, required 3", lat); end
        checks++;
        if (pop_cnt - q0 !== 0) begin errors++; $display("FAIL underflow_strobe: got %0d, required 0", pop_cnt - q0); end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL underflow_count: got %0d, required 0", count); end
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL underflow_rdata_hold: got %h, required 00", rd); end
    endtask

    task automatic test_full();
        bit err; logic [DW-1:0] rd; int lat; int p0; int bad;
        logic [DW-1:0] exp_v;
        p0 = push_cnt; bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            do_txn(0, 1, DW'(i), err, rd, lat);
            if (err) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fill_err: got %0d errors, required 0", bad); end
        checks++;
        if (count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d, required 16", count); end
        p0 = push_cnt;
        do_txn(0, 1, 8'hC2, err, rd, lat);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b, required 1", err); end
        checks++;
        if (push_cnt - p0 !== 0) begin errors++; $display("FAIL overflow_strobe: got %0d, required 0", push_cnt - p0); end
        checks++;
        if (count !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d, required 16", count); end
        exp_q.delete();
        for (int i = DEPTH - 1; i >= 0; i--) exp_q.push_back(DW'(i));
        for (int i = 0; i < DEPTH; i++) begin
            do_txn(0, 0, 8'h00, err, rd, lat);
            exp_v = exp_q.pop_front();
            checks++;
            if (err !== 1'b0 || rd !== exp_v) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %h err=%b, required %h err=0", i, rd, err, exp_v);
            end
        end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d, required 0", count); end
        checks++;
        if (r1_rdata !== 8'hA4) begin errors++; $display("FAIL r1_rdata_hold: got %h, required a4", r1_rdata); end
    endtask

    task automatic test_back_to_back();
        int acks_seen; bit ack_id[$];
        logic [DW-1:0] exp_v;
        apply_reset();
        push_log.delete();
        exp_q.delete();
        acks_seen = 0;
        @(negedge clk);
        r0_req = 1; r0_op = 1; r0_wdata = 8'h11;
        r1_req = 1; r1_op = 1; r1_wdata = 8'h22;
        for (int i = 0; i < 60 && acks_seen < 6; i++) begin
            @(negedge clk);
            if (r0_ack) begin ack_id.push_back(1'b0); acks_seen++; end
            if (r1_ack) begin ack_id.push_back(1'b1); acks_seen++; end
        end
        r0_req = 0; r1_req = 0;
        checks++;
        if (acks_seen != 6) begin errors++; $display("FAIL rr_acks: got %0d, required 6", acks_seen); end
        for (int i = 0; i < 6; i++) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
            exp_q.push_back(8'h11);
`else
            exp_q.push_back((i % 2 == 0) ? 8'h11 : 8'h22);
`endif
        end
        for (int i = 0; i < 6; i++) begin
            exp_v = exp_q[i];
            checks++;
            if (i >= push_log.size() || push_log[i] !== exp_v) begin
                errors++;
                $display("FAIL rr_push_data[%0d]: got %h, required %h", i,
                         (i < push_log.size()) ? push_log[i] : 8'hxx, exp_v);
            end
            checks++;
            if (i >= ack_id.size() || ack_id[i] !== (exp_v == 8'h22)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got r%0d, required r%0d", i,
                         (i < ack_id.size()) ? ack_id[i] : 1'b0, (exp_v == 8'h22));
            end
        end
        @(negedge clk);
        checks++;
        if (count !== 5'd6) begin errors++; $display("FAIL rr_count: got %0d, required 6", count); end
    endtask

    task automatic test_reset_mid_capture();
        bit err; logic [DW-1:0] rd; int lat; bit hit; bit ack_seen;
        hit = 0; ack_seen = 0;
        @(negedge clk);
        r1_req = 1; r1_op = 0; r1_wdata = 8'h00;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (dbg_state == 2'd2) hit = 1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_reach_capture: state %0d, required 2", dbg_state); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({r0_ack, r0_err, r1_ack, r1_err, stk_push, stk_pop} !== 6'b0 ||
            {r0_rdata, r1_rdata, stk_data_in} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags %b data %h, required all 0",
                     {r0_ack, r0_err, r1_ack, r1_err, stk_push, stk_pop},
                     {r0_rdata, r1_rdata, stk_data_in});
        end
        checks++;
        if (count !== 5'd0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_count_state: got count %0d state %0d, required 0 0", count, dbg_state);
        end
        r1_req = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (r0_ack || r1_ack) ack_seen = 1;
        end
        checks++;
        if (ack_seen) begin errors++; $display("FAIL mid_reset_no_ack: got ack, required none"); end
        do_txn(0, 0, 8'h00, err, rd, lat);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL mid_reset_pop_err: got %b, required 1", err); end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL mid_reset_pop_count: got %0d, required 0", count); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_push_basic();
        test_pop_basic();
        test_underflow();
        test_full();
        test_back_to_back();
        test_reset_mid_capture();
        checks++;
        if (both_seen) begin errors++; $display("FAIL strobe_exclusive: push and pop high together, required never"); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one synchronous push/pop stack between two requesters (r0, r1).
- Each requester issues push or pop transactions over a req/ack handshake.
- The arbiter serialises the transactions onto the stack's push/pop/data_in port and returns popped data with an ack.
- Tracks stack occupancy internally, so it rejects overflow and underflow before they reach the stack.

Parameters:
- DATA_WIDTH, 8, width of stack entries and requester data buses.
- DEPTH, 16, stack capacity in entries; must match the attached stack instance.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 transaction request; held until r0_ack.
- r0_op  in  1  requester 0 op: 1=push, 0=pop; stable while r0_req=1.
- r0_wdata  in  DATA_WIDTH  requester 0 push data; stable while r0_req=1.
- r0_ack  out  1  one-cycle completion pulse to requester 0.
- r0_err  out  1  valid with r0_ack: 1 = rejected (overflow/underflow).
- r0_rdata  out  DATA_WIDTH  popped data; valid with r0_ack when r0_op=0 and r0_err=0.
- r1_req, r1_op, r1_wdata, r1_ack, r1_err, r1_rdata  same as r0_*, for requester 1.
- stk_push  out  1  push strobe to stack.
- stk_pop  out  1  pop strobe to stack.
- stk_data_in  out  DATA_WIDTH  push data to stack.
- stk_data_out  in  DATA_WIDTH  stack read data; valid the cycle after stk_pop.
- stk_empty  in  1  stack empty flag; used for a consistency check only.
- count  out  CNT_W  current occupancy as tracked by the arbiter.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, count=0, rr_last=1 (so r0 wins first), and every output 0, including all ack, err, rdata and stk_* outputs.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req is high, select a winner and latch op, wdata and id, then go to ISSUE.
  - Round-robin: when both requesters are high, grant the one not granted last. A single requester is granted immediately.
- ISSUE:
  - Push with count<DEPTH: stk_push=1 and stk_data_in=wdata for exactly one cycle; count+1; go to RESP.
  - Pop with count>0: stk_pop=1 for one cycle; count-1; go to CAPTURE.
  - Push with count==DEPTH, or pop with count==0: no stk strobe; set err; go to RESP.
- CAPTURE: register stk_data_out into the winner's rdata; go to RESP.
- RESP:
  - Drive the winner's ack=1 for one cycle, with err as latched; update rr_last; go to IDLE.
  - Err is also cleared on entry to IDLE.
- Latency: push = 3 cycles from req sampled in IDLE to ack; pop = 4 cycles. Only one transaction is in flight; no back-to-back overlap.
- rdata holds its last value until the next successful pop for that requester. It is not cleared on push or on err.
- The requester must drop req in the cycle after ack or present a new transaction. A req still high in IDLE after its ack is treated as a new request.
- The losing requester keeps req high; it is served next (round-robin guarantees service within one transaction).
- stk_push and stk_pop are never high in the same cycle and are never asserted outside ISSUE.
- Simultaneous r0/r1 requests with opposite ops: each transaction is arbitrated independently. There is no merging.
- Reset mid-transaction: immediate abort; no ack is issued; count=0. The stack must be reset by the same reset_n.
- count never wraps; the saturation checks above guarantee 0≤count≤DEPTH.
- stk_empty must equal (count==0) whenever the FSM is in IDLE. A simulation-only assertion flags a mismatch; it has no functional effect.

Optional Feature:
- STACK_ARB_FIXED_PRIO_EN
  - Defined: r0 always wins when both req are high; rr_last is not implemented. r1 is served only when r0_req=0 in IDLE, so r1 can starve.
  - Undefined (default): round-robin as specified.

Test Plan:
- Reset, then r0 push 8'hA4 → stk_push pulse with stk_data_in=A4; r0_ack after 3 cycles; r0_err=0; count=1.
- r1 pop after the above → stk_pop pulse; r1_ack after 4 cycles; r1_rdata=A4; count=0.
- Pop with count=0 → no stk_pop; r0_ack with r0_err=1; count stays 0.
- DEPTH=16: 16 pushes of 8'h00..8'h0F, then a 17th push of 8'hC2 → err=1, no stk_push, count=16. Then 16 pops → data 0F..00 in order.
- r0 and r1 both push continuously (r0=8'h11, r1=8'h22) → grants alternate r0,r1,r0,…; with STACK_ARB_FIXED_PRIO_EN defined, r0 only.
- reset_n low during CAPTURE → all outputs 0 immediately; no ack; count=0; a subsequent pop returns err=1.
